// File: rtl/xor_parity_frame_checker_if.sv
// rtl/xor_parity_frame_checker_if.sv - stream and status bundle for the parity frame checker
interface xor_parity_frame_checker_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             parity_mode;
  logic             abort;
  logic             in_valid;
  logic             in_bit;
  logic             busy;
  logic             out_valid;
  logic             out_parity;
  logic             out_err;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output start,
    output parity_mode,
    output abort,
    output in_valid,
    output in_bit,
    input  busy,
    input  out_valid,
    input  out_parity,
    input  out_err,
    input  frame_count,
    input  err_count
  );

  modport slave (
    input  start,
    input  parity_mode,
    input  abort,
    input  in_valid,
    input  in_bit,
    output busy,
    output out_valid,
    output out_parity,
    output out_err,
    output frame_count,
    output err_count
  );
endinterface

// File: rtl/xor_parity_frame_checker.sv
// rtl/xor_parity_frame_checker.sv - serial running-XOR parity checker with frame and error counters
module xor_parity_frame_checker #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  xor_parity_frame_checker_if.slave   bus
);

  // bit counter must be able to hold DATA_BITS; clog2(DATA_BITS+1) is at least 1 for DATA_BITS >= 1
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_CHECK  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             acc;
  logic [BCW-1:0]   bit_cnt;
  logic             out_parity_q;
  logic             out_err_q;
  logic [CNT_W-1:0] frame_count_q;
  logic [CNT_W-1:0] err_count_q;
  logic             busy_c;
  logic             out_valid_c;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state decode; abort wins over a simultaneous in_valid
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.abort) begin
          state_nx = S_IDLE;
        end else if (bus.in_valid && (bit_cnt == LAST_BIT)) begin
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bus.abort) begin
          state_nx = S_IDLE;
        end else if (bus.in_valid) begin
          state_nx = S_RESULT;
        end
      end
      S_RESULT: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy_c      = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      S_DATA:   busy_c = 1'b1;
      S_CHECK:  busy_c = 1'b1;
      S_RESULT: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
      end
      default: begin
        busy_c      = 1'b0;
        out_valid_c = 1'b0;
      end
    endcase
  end

  // accumulator, result latches and counters; seeding acc with parity_mode folds in the odd-mode inversion
  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= 1'b0;
      bit_cnt       <= '0;
      out_parity_q  <= 1'b0;
      out_err_q     <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            acc     <= bus.parity_mode;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (!bus.abort && bus.in_valid) begin
            acc     <= acc ^ bus.in_bit;
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
        S_CHECK: begin
          if (!bus.abort && bus.in_valid) begin
            out_parity_q <= acc;
            out_err_q    <= acc ^ bus.in_bit;
          end
        end
        S_RESULT: begin
          frame_count_q <= frame_count_q + CNT_W'(1);
          if (out_err_q && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_q <= err_count_q + CNT_W'(1);
          end
        end
        default: begin
          acc <= acc;
        end
      endcase
    end
  end

  assign bus.busy        = busy_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_parity  = out_parity_q;
  assign bus.out_err     = out_err_q;
  assign bus.frame_count = frame_count_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_xor_parity_frame_checker.sv
// tb/tb_xor_parity_frame_checker.sv - directed self-checking bench for xor_parity_frame_checker
module tb_xor_parity_frame_checker;

  logic clk;
  logic rst;

  int checks;
  int errors;
  int pulses_a;
  int pulses_b;

  xor_parity_frame_checker_if #(.CNT_W(8)) ifa ();
  xor_parity_frame_checker_if #(.CNT_W(2)) ifb ();

  xor_parity_frame_checker #(.DATA_BITS(8), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  xor_parity_frame_checker #(.DATA_BITS(1), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count result pulses on the inactive edge
  always @(negedge clk) begin
    if (!rst && ifa.out_valid) pulses_a <= pulses_a + 1;
    if (!rst && ifb.out_valid) pulses_b <= pulses_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_a(input logic mode, input logic [7:0] data, input logic par,
                         input logic gaps, input logic exp_par, input logic exp_err);
    ifa.start       = 1'b1;
    ifa.parity_mode = mode;
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        ifa.in_valid = 1'b0;
        tick();
      end
      ifa.in_valid = 1'b1;
      ifa.in_bit   = data[i];
      tick();
    end
    check("a_pre_valid", 32'(ifa.out_valid), 32'd0);
    ifa.in_valid = 1'b1;
    ifa.in_bit   = par;
    tick();
    ifa.in_valid = 1'b0;
    ifa.in_bit   = 1'b0;
    check("a_valid", 32'(ifa.out_valid), 32'd1);
    check("a_parity", 32'(ifa.out_parity), 32'(exp_par));
    check("a_err", 32'(ifa.out_err), 32'(exp_err));
    tick();
    check("a_valid_drop", 32'(ifa.out_valid), 32'd0);
    check("a_idle", 32'(ifa.busy), 32'd0);
  endtask

  task automatic frame_b(input logic d, input logic par);
    ifb.start       = 1'b1;
    ifb.parity_mode = 1'b0;
    tick();
    ifb.start    = 1'b0;
    ifb.in_valid = 1'b1;
    ifb.in_bit   = d;
    tick();
    ifb.in_bit = par;
    tick();
    ifb.in_valid = 1'b0;
    check("b_valid", 32'(ifb.out_valid), 32'd1);
    tick();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    pulses_a = 0;
    pulses_b = 0;
    rst = 1'b1;
    ifa.start = 1'b0; ifa.parity_mode = 1'b0; ifa.abort = 1'b0; ifa.in_valid = 1'b0; ifa.in_bit = 1'b0;
    ifb.start = 1'b0; ifb.parity_mode = 1'b0; ifb.abort = 1'b0; ifb.in_valid = 1'b0; ifb.in_bit = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_valid", 32'(ifa.out_valid), 32'd0);
    check("rst_parity", 32'(ifa.out_parity), 32'd0);
    check("rst_err", 32'(ifa.out_err), 32'd0);
    check("rst_fc", 32'(ifa.frame_count), 32'd0);
    check("rst_ec", 32'(ifa.err_count), 32'd0);

    // even, 0xA5, parity 0
    frame_a(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("f1_fc", 32'(ifa.frame_count), 32'd1);
    check("f1_ec", 32'(ifa.err_count), 32'd0);

    // even, 0x07, parity 0 -> mismatch
    frame_a(1'b0, 8'h07, 1'b0, 1'b0, 1'b1, 1'b1);
    check("f2_fc", 32'(ifa.frame_count), 32'd2);
    check("f2_ec", 32'(ifa.err_count), 32'd1);
    ifa.in_valid = 1'b1;
    ifa.in_bit   = 1'b1;
    ifa.abort    = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ifa.in_valid = 1'b0;
    ifa.in_bit   = 1'b0;
    ifa.abort    = 1'b0;
    check("f2_err_held", 32'(ifa.out_err), 32'd1);
    check("f2_idle_busy", 32'(ifa.busy), 32'd0);

    // odd, 0x07, parity 0
    frame_a(1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    // odd, 0x00, parity 1
    frame_a(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    // even, 0xA5 with alternate-cycle gaps
    frame_a(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    check("f5_fc", 32'(ifa.frame_count), 32'd5);
    check("f5_ec", 32'(ifa.err_count), 32'd1);
    check("f5_pulses", 32'(pulses_a), 32'd5);

    // abort after 4 data bits, abort beating in_valid
    ifa.start = 1'b1;
    ifa.parity_mode = 1'b0;
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifa.in_valid = 1'b1;
      ifa.in_bit   = 1'b1;
      tick();
    end
    ifa.abort = 1'b1;
    tick();
    ifa.abort    = 1'b0;
    ifa.in_valid = 1'b0;
    check("abort_busy", 32'(ifa.busy), 32'd0);
    tick();
    check("abort_no_valid", 32'(pulses_a), 32'd5);
    frame_a(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_fc", 32'(ifa.frame_count), 32'd6);
    check("abort_ec", 32'(ifa.err_count), 32'd1);
    check("abort_pulses", 32'(pulses_a), 32'd6);

    // reset mid-DATA
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifa.in_valid = 1'b1;
      ifa.in_bit   = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 32'(ifa.busy), 32'd0);
    check("mid_rst_fc", 32'(ifa.frame_count), 32'd0);
    check("mid_rst_ec", 32'(ifa.err_count), 32'd0);
    check("mid_rst_err", 32'(ifa.out_err), 32'd0);
    for (int i = 0; i < 12; i++) tick();
    ifa.in_valid = 1'b0;
    check("mid_rst_no_valid", 32'(pulses_a), 32'd6);
    check("mid_rst_still_idle", 32'(ifa.busy), 32'd0);

    // narrow counters, single-bit frames, all with wrong parity
    for (int k = 1; k <= 5; k++) begin
      frame_b(1'b1, 1'b0);
      check("b_err", 32'(ifb.out_err), 32'd1);
      check("b_fc", 32'(ifb.frame_count), 32'(k % 4));
      check("b_ec", 32'(ifb.err_count), 32'((k < 3) ? k : 3));
    end
    check("b_pulses", 32'(pulses_b), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_parity_frame_checker.md
Name: xor_parity_frame_checker

Overview:
- Serial parity accumulator and checker that sits downstream of the two-input XOR gate stage.
- It folds a serial bit stream through a running XOR over a frame of DATA_BITS data bits.
- It then compares the result against a trailing received parity bit and reports the expected parity, a mismatch flag, and running frame and error counters.
- It is used as the sequential consumer of XOR results in the basic-gates test designs.

Parameters:
- DATA_BITS, 8, number of data bits per frame (minimum 1); the parity bit is not counted.
- CNT_W, 8, width of frame_count and err_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a frame; sampled only in IDLE.
- parity_mode  input  1  0 = even parity, 1 = odd parity; latched on the cycle start is accepted.
- abort  input  1  drop the current frame; effective in DATA and CHECK only.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data or parity bit.
- busy  output  1  high in DATA, CHECK and RESULT.
- out_valid  output  1  one-cycle pulse when a frame result is ready.
- out_parity  output  1  expected parity bit for the completed frame; held until the next result.
- out_err  output  1  received parity mismatch; held until the next result.
- frame_count  output  CNT_W  completed frames; wraps modulo 2^CNT_W.
- err_count  output  CNT_W  frames with out_err=1; saturates at all-ones.

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - state=IDLE.
  - All outputs 0; acc=0, bit_cnt=0, frame_count=0, err_count=0.
  - Reset overrides all other inputs, including mid-frame; no out_valid is produced for an interrupted frame.
- States: IDLE, DATA, CHECK, RESULT; encoding is free.
- IDLE:
  - busy=0.
  - start=1 causes: acc <= parity_mode, bit_cnt <= 0, go to DATA.
  - in_valid and abort are ignored.
- DATA:
  - On each cycle with in_valid=1: acc <= acc ^ in_bit, bit_cnt <= bit_cnt+1.
  - Gaps (in_valid=0) hold state.
  - When in_valid=1 and bit_cnt==DATA_BITS-1, go to CHECK.
  - bit_cnt width is clog2(DATA_BITS+1), minimum 1.
- CHECK:
  - On the in_valid=1 cycle, in_bit is the received parity p.
  - out_parity <= acc, out_err <= acc ^ p, go to RESULT.
- RESULT:
  - Lasts exactly one cycle; out_valid=1.
  - frame_count increments (wraps).
  - err_count increments if out_err=1, unless already all-ones.
  - Unconditional transition to IDLE.
- Abort:
  - In DATA or CHECK, abort=1 returns to IDLE at that edge and beats any simultaneous in_valid.
  - An aborted frame updates no outputs or counters.
  - Abort is ignored in IDLE and RESULT.
- Start outside IDLE is ignored.
  - The earliest new frame starts with start=1 in the IDLE cycle following RESULT.
  - Minimum frame-to-frame spacing is DATA_BITS+3 cycles.
- Latency:
  - out_valid rises in the cycle immediately after the edge that samples the parity bit.
  - out_parity and out_err are updated on that same edge and are stable while out_valid=1.
- Parity definition:
  - Even mode: expected parity = XOR of the data bits.
  - Odd mode: expected parity = inverted XOR of the data bits.
  - out_err=1 when the received parity differs from expected.
- Bit order is LSB first by convention; the result is order-independent.
- DATA_BITS=1: DATA accepts a single bit, then goes to CHECK.

Test Plan:
- Reset then even mode, data 0xA5 (four ones), parity 0 -> out_valid pulse, out_parity=0, out_err=0, frame_count=1, err_count=0.
- Even mode, data 0x07 (three ones), parity 0 -> out_parity=1, out_err=1, err_count=1; out_err stays 1 while idle.
- Odd mode, data 0x07, parity 0 -> out_parity=0, out_err=0.
- Odd mode, data 0x00, parity 1 -> out_err=0.
- Even mode, 0xA5 with in_valid low on alternate cycles -> same result as the contiguous case, and out_valid appears one cycle after the parity bit.
- Abort after 4 data bits, then a full 0xFF frame with parity 0 -> exactly one out_valid, out_err=0, frame_count +1 only.
- rst asserted mid-DATA -> next cycle busy=0, all counters 0, no out_valid.
- CNT_W=2: five frames, each with a wrong parity bit -> err_count=3 (saturated), frame_count wraps 3 -> 0 -> 1.
